// File: rtl/pwm_fade_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : pwm_fade_sequencer_if
// Description : Control/status bundle between a sequencer master and the
//               PWM fade sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pwm_fade_sequencer_if #(
  parameter int NUM_CH = 5
);
  logic              start;
  logic              stop;
  logic [NUM_CH-1:0] ch_mask;
  logic              busy;
  logic [7:0]        level_out;
  logic [NUM_CH-1:0] ch_sel;
  logic              cycle_done;

  modport master (
    output start, stop, ch_mask,
    input  busy, level_out, ch_sel, cycle_done
  );

  modport slave (
    input  start, stop, ch_mask,
    output busy, level_out, ch_sel, cycle_done
  );
endinterface

`default_nettype wire

// File: rtl/pwm_fade_sequencer.sv
//------------------------------------------------------------------------------
// Module      : pwm_fade_sequencer
// Description : Ramps a shared 8-bit PWM level up/hold/down on each enabled
//               LED channel in turn. Optional macro PWM_GAMMA_EN squares the
//               output level for perceptual brightness.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pwm_fade_sequencer #(
  parameter int NUM_CH     = 5,
  parameter int DIV_W      = 16,
  parameter int HOLD_TICKS = 32
) (
  input  wire logic            ICE_CLK,
  input  wire logic            RST,
  pwm_fade_sequencer_if.slave  bus
);

  localparam int IW = $clog2(NUM_CH);
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HW-1:0] c_HOLD_LAST = HW'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

  localparam logic [2:0] c_S_IDLE = 3'd0;
  localparam logic [2:0] c_S_UP   = 3'd1;
  localparam logic [2:0] c_S_HOLD = 3'd2;
  localparam logic [2:0] c_S_DOWN = 3'd3;
  localparam logic [2:0] c_S_NEXT = 3'd4;

  logic [2:0]       r_state;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_level;
  logic [HW-1:0]    r_hold;
  logic [IW-1:0]    r_ch_idx;
  logic             r_cd;

  logic             w_tick;
  logic [IW-1:0]    w_first;
  logic [IW-1:0]    w_next;
  logic             w_wrap;

  function automatic logic [IW-1:0] f_wrap(input int v);
    return IW'(v % NUM_CH);
  endfunction

  assign w_tick = (&r_div) && (r_state != c_S_IDLE);

  // Highest-priority match is the smallest forward distance from the current channel.
  always_comb begin
    w_first = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.ch_mask[i]) w_first = IW'(i);
    end
    w_next = r_ch_idx;
    for (int j = NUM_CH; j >= 1; j--) begin
      if (bus.ch_mask[f_wrap(int'(r_ch_idx) + j)]) w_next = f_wrap(int'(r_ch_idx) + j);
    end
    w_wrap = (w_next <= r_ch_idx);
  end

  always_ff @(posedge ICE_CLK) begin
    if (RST) begin
      r_state  <= c_S_IDLE;
      r_div    <= '0;
      r_level  <= 8'h00;
      r_hold   <= '0;
      r_ch_idx <= '0;
      r_cd     <= 1'b0;
    end else begin
      r_cd  <= 1'b0;
      r_div <= (r_state == c_S_IDLE) ? '0 : r_div + DIV_W'(1);
      if (bus.stop) begin
        r_state  <= c_S_IDLE;
        r_div    <= '0;
        r_level  <= 8'h00;
        r_hold   <= '0;
        r_ch_idx <= '0;
      end else begin
        case (r_state)
          c_S_IDLE: begin
            if (bus.start && (|bus.ch_mask)) begin
              r_state  <= c_S_UP;
              r_ch_idx <= w_first;
              r_level  <= 8'h00;
            end
          end
          c_S_UP: begin
            if (w_tick) begin
              r_level <= r_level + 8'd1;
              if (r_level == 8'hFE) begin
                r_hold  <= '0;
                r_state <= (HOLD_TICKS == 0) ? c_S_DOWN : c_S_HOLD;
              end
            end
          end
          c_S_HOLD: begin
            if (w_tick) begin
              if (r_hold == c_HOLD_LAST) r_state <= c_S_DOWN;
              else                       r_hold  <= r_hold + HW'(1);
            end
          end
          c_S_DOWN: begin
            if (w_tick) begin
              r_level <= r_level - 8'd1;
              if (r_level == 8'h01) r_state <= c_S_NEXT;
            end
          end
          c_S_NEXT: begin
            if (|bus.ch_mask) begin
              r_state  <= c_S_UP;
              r_ch_idx <= w_next;
              r_cd     <= w_wrap;
              r_level  <= 8'h00;
            end else begin
              r_state  <= c_S_IDLE;
              r_ch_idx <= '0;
            end
          end
          default: r_state <= c_S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy       = (r_state != c_S_IDLE);
  assign bus.ch_sel     = bus.busy ? (NUM_CH'(1) << r_ch_idx) : '0;
  assign bus.cycle_done = r_cd;

`ifdef PWM_GAMMA_EN
  logic [15:0] w_sq;
  assign w_sq          = r_level * r_level;
  assign bus.level_out = w_sq[15:8];
`else
  assign bus.level_out = r_level;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pwm_fade_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_pwm_fade_sequencer
// Description : Self-checking bench for pwm_fade_sequencer against a
//               tick-count reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pwm_fade_sequencer;

  localparam int NUM_CH = 5;
  localparam int DIV_W  = 2;
  localparam int H      = 4;
  localparam int PER    = 1 << DIV_W;
  localparam int LAST_K = 510 + H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_fade_sequencer_if #(.NUM_CH(NUM_CH)) bus ();

  pwm_fade_sequencer #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .HOLD_TICKS(H)) dut (
    .ICE_CLK (clk),
    .RST     (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [NUM_CH-1:0] tb_mask = '0;

  // Reference model: position within a channel is just the tick count k.
  bit m_busy = 0, m_next = 0, m_cd = 0;
  int m_ch = 0, m_k = 0, m_t = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_level();
    int l;
    if (!m_busy || m_next) l = 0;
    else if (m_k <= 255) l = m_k;
    else if (m_k <= 255 + H) l = 255;
    else l = 255 - (m_k - 255 - H);
`ifdef PWM_GAMMA_EN
    return (l * l) >> 8;
`else
    return l;
`endif
  endfunction

  function automatic int pick(input logic [NUM_CH-1:0] m, input int from, input int d0);
    for (int d = d0; d < d0 + NUM_CH; d++) begin
      if (m[(from + d) % NUM_CH]) return (from + d) % NUM_CH;
    end
    return 0;
  endfunction

  task automatic model(input bit r, input bit s, input bit p, input logic [NUM_CH-1:0] m);
    int n;
    m_cd = 0;
    if (r) begin
      m_busy = 0; m_next = 0; m_ch = 0; m_k = 0; m_t = 0;
    end else if (p) begin
      m_busy = 0; m_next = 0;
    end else if (!m_busy) begin
      if (s && m != 0) begin
        m_busy = 1; m_ch = pick(m, 0, 0); m_k = 0; m_t = 0; m_next = 0;
      end
    end else if (m_next) begin
      if (m == 0) begin
        m_busy = 0; m_next = 0;
      end else begin
        n = pick(m, m_ch, 1);
        m_cd = (n <= m_ch);
        m_ch = n; m_k = 0; m_next = 0; m_t++;
      end
    end else begin
      if (m_t % PER == PER - 1) begin
        m_k++;
        if (m_k == LAST_K) m_next = 1;
      end
      m_t++;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit p);
    rst = r; bus.start = s; bus.stop = p; bus.ch_mask = tb_mask;
    @(posedge clk);
    model(r, s, p, tb_mask);
    #1;
    bus.start = 1'b0; bus.stop = 1'b0; rst = 1'b0;
    check("busy", {31'b0, bus.busy}, {31'b0, m_busy});
    check("level", {24'b0, bus.level_out}, exp_level());
    check("ch_sel", {27'b0, bus.ch_sel}, m_busy ? (32'd1 << m_ch) : 32'd0);
    check("cycle_done", {31'b0, bus.cycle_done}, {31'b0, m_cd});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic run_until_k(input int k, input string tag);
    int g = 0;
    while (!(m_busy && !m_next && m_k == k) && g < 3000) begin
      step(0, 0, 0);
      g++;
    end
    check(tag, {31'b0, g < 3000}, 32'd1);
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.ch_mask = '0;
    step(1, 0, 0);
    step(1, 0, 0);
    check("reset_level", {24'b0, bus.level_out}, 32'd0);

    // Two channels, through the wrap back to channel 0.
    tb_mask = 5'b00101;
    step(0, 1, 0);
    check("start_sel", {27'b0, bus.ch_sel}, 32'b00001);
    run(2 * (LAST_K * PER + 1) + 40);

    // Stop mid ramp at level 0x40, then start with an empty mask.
    run_until_k(64, "reach_40");
    check("at_40", {24'b0, bus.level_out}, exp_level());
    step(0, 0, 1);
    check("stop_busy", {31'b0, bus.busy}, 32'd0);
    tb_mask = '0;
    step(0, 1, 0);
    run(10);
    check("empty_start", {31'b0, bus.busy}, 32'd0);

    // Mask change mid channel plus start while busy.
    tb_mask = 5'b00101;
    step(0, 1, 0);
    run(100);
    tb_mask = 5'b00010;
    step(0, 1, 0);
    run_until_k(LAST_K - 1, "reach_end");
    run(PER + 2);
    check("mask_next_sel", {27'b0, bus.ch_sel}, 32'b00010);
    run(300);

    // Start+stop together while busy, then reset during hold.
    step(0, 1, 1);
    check("startstop_idle", {31'b0, bus.busy}, 32'd0);
    tb_mask = 5'b10001;
    step(0, 1, 0);
    run_until_k(257, "reach_hold");
    step(1, 1, 0);
    check("rst_sel", {27'b0, bus.ch_sel}, 32'd0);

    // Randomized control traffic.
    for (int i = 0; i < 15000; i++) begin
      if ($urandom % 512 == 0) tb_mask = NUM_CH'($urandom % 32);
      step(($urandom % 8192) == 0, ($urandom % 64) == 0, ($urandom % 2048) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
